score_keeper: RTL
=================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points needed to win (range 1..15).
REQ-002 SHALL have parameter SERVE_CYCLES, default 50000000, clk cycles the ball is held after a point (range 2..2^26-1).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level; high requests a new game from IDLE or OVER.
REQ-006 SHALL have port player_0_scores  input  1  level from ball block; high when player 0 wins a point.
REQ-007 SHALL have port player_1_scores  input  1  level from ball block; high when player 1 wins a point.
REQ-008 SHALL have port score_0  output  4  player 0 point count.
REQ-009 SHALL have port score_1  output  4  player 1 point count.
REQ-010 SHALL have port ball_resetn  output  1  active-low hold to ball block; low holds ball at centre.
REQ-011 SHALL have port point  output  1  one-cycle pulse per counted point.
REQ-012 SHALL have port game_over  output  1  high in OVER.
REQ-013 SHALL have port winner  output  1  0 = player 0 won, 1 = player 1 won; valid while game_over is high.

Function
REQ-014 SHALL register each score input once (s0_q, s1_q); a rising edge is input high AND its previous registered value low.
REQ-015 SHALL implement FSM states IDLE, PLAY, SERVE, OVER.
REQ-016 IDLE: ball_resetn=0; start=1 -> SERVE, scores cleared to 0, serve counter loaded.
REQ-017 SERVE: ball_resetn=0; serve counter decrements each cycle; transition to PLAY on the cycle the counter reaches 0 (exactly SERVE_CYCLES cycles in SERVE).
REQ-018 PLAY: ball_resetn=1; score edges are evaluated only in PLAY; edges in other states are ignored.
REQ-019 A single edge in PLAY SHALL increment that player's score (4-bit), assert point for one cycle, load the serve counter and go to SERVE.
REQ-020 Both edges in the same cycle SHALL count no point, keep point low, and go to SERVE (point replayed).
REQ-021 When an increment makes a score equal WIN_SCORE, SHALL go to OVER instead of SERVE, set winner to that player, still pulse point.
REQ-022 Scores SHALL never exceed WIN_SCORE; no wrap-around.
REQ-023 OVER: ball_resetn=0, game_over=1, scores and winner held; start=1 -> SERVE with scores cleared.
REQ-024 start SHALL be ignored in PLAY and SERVE.
REQ-025 point, game_over, ball_resetn SHALL be registered (no combinational path from inputs).

Reset
REQ-026 resetn=0 SHALL immediately force state IDLE, score_0=0, score_1=0, point=0, game_over=0, winner=0, ball_resetn=0, serve counter=0, s0_q=s1_q=0.
REQ-027 Reset asserted mid-SERVE or mid-PLAY SHALL abandon the game with no point pulse; operation resumes only via start.

Verification (SERVE_CYCLES=4, WIN_SCORE=3 for bench)
REQ-028 Reset then start pulse -> SERVE for exactly 4 cycles with ball_resetn=0, then PLAY with ball_resetn=1, scores 0/0.
REQ-029 In PLAY, player_1_scores held high 10 cycles -> score_1=1, exactly one point pulse, SERVE entered; later high level ignored.
REQ-030 Both score inputs rise in the same PLAY cycle -> scores unchanged, point=0, SERVE entered.
REQ-031 Player 0 scores 3 times -> score_0=3, game_over=1, winner=0, ball_resetn=0; further edges leave scores 3/x.
REQ-032 In OVER, start=1 -> scores 0/0, game_over=0, SERVE entered; start during PLAY has no effect.
REQ-033 resetn pulsed low mid-SERVE (asynchronous, between clock edges) -> all outputs at reset values before next clk edge, state IDLE.

Source files
------------

// File: rtl/score_keeper.sv
// Score keeper for a two-player ball game: edge-detects point inputs, counts
// scores to WIN_SCORE, and holds the ball during a timed serve after each point.
module score_keeper #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       player_0_scores,
  input  logic       player_1_scores,
  output logic [3:0] score_0,
  output logic [3:0] score_1,
  output logic       ball_resetn,
  output logic       point,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned CntW = 26;
  localparam logic [CntW-1:0] ServeLoad = CntW'(SERVE_CYCLES - 1);
  localparam logic [3:0] WinVal = 4'(WIN_SCORE);

  typedef enum logic [1:0] {StIdle, StServe, StPlay, StOver} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      score_0_q, score_0_d;
  logic [3:0]      score_1_q, score_1_d;
  logic            winner_q, winner_d;
  logic            point_q, point_d;
  logic            game_over_q;
  logic            ball_resetn_q;
  logic            s0_q, s1_q;
  logic            rise_0, rise_1;
  logic [3:0]      inc_0, inc_1;

  assign rise_0 = player_0_scores & ~s0_q;
  assign rise_1 = player_1_scores & ~s1_q;
  assign inc_0  = score_0_q + 4'd1;
  assign inc_1  = score_1_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_0_d = score_0_q;
    score_1_d = score_1_q;
    winner_d  = winner_q;
    point_d   = 1'b0;
    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d   = StServe;
          cnt_d     = ServeLoad;
          score_0_d = 4'd0;
          score_1_d = 4'd0;
          winner_d  = 1'b0;
        end
      end
      StServe: begin
        // Counter is loaded with SERVE_CYCLES-1 so the hold lasts SERVE_CYCLES cycles.
        if (cnt_q == '0) begin
          state_d = StPlay;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPlay: begin
        if (rise_0 && rise_1) begin
          state_d = StServe;
          cnt_d   = ServeLoad;
        end else if (rise_0) begin
          score_0_d = inc_0;
          point_d   = 1'b1;
          if (inc_0 == WinVal) begin
            state_d  = StOver;
            winner_d = 1'b0;
          end else begin
            state_d = StServe;
            cnt_d   = ServeLoad;
          end
        end else if (rise_1) begin
          score_1_d = inc_1;
          point_d   = 1'b1;
          if (inc_1 == WinVal) begin
            state_d  = StOver;
            winner_d = 1'b1;
          end else begin
            state_d = StServe;
            cnt_d   = ServeLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      score_0_q     <= 4'd0;
      score_1_q     <= 4'd0;
      winner_q      <= 1'b0;
      point_q       <= 1'b0;
      game_over_q   <= 1'b0;
      ball_resetn_q <= 1'b0;
      s0_q          <= 1'b0;
      s1_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_0_q     <= score_0_d;
      score_1_q     <= score_1_d;
      winner_q      <= winner_d;
      point_q       <= point_d;
      game_over_q   <= (state_d == StOver);
      ball_resetn_q <= (state_d == StPlay);
      s0_q          <= player_0_scores;
      s1_q          <= player_1_scores;
    end
  end

  assign score_0     = score_0_q;
  assign score_1     = score_1_q;
  assign ball_resetn = ball_resetn_q;
  assign point       = point_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule
